// File: rtl/sodor_imem_pkg.sv
// Shared constants and response type for the Sodor instruction-fetch memory port.
package sodor_imem_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h00000013;

   typedef struct packed {
      logic [XLEN-1:0] data;
      logic            err;
   } imem_resp_t;

endpackage

// File: rtl/sodor_imem_rom.sv
// Word-addressed text ROM with a registered read; contents are loaded by the environment, never reset.
module sodor_imem_rom
   import sodor_imem_pkg::*;
#(
   parameter int DEPTH = 600,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic            clock,
   input  logic            en,
   input  logic [AW-1:0]   addr,
   output logic [XLEN-1:0] dout
);

   logic [XLEN-1:0] mem [DEPTH];

   always_ff @(posedge clock) begin
      if (en) dout <= mem[addr];
   end

endmodule

// File: rtl/sodor_imem_port.sv
// Instruction-fetch port: address check, registered ROM read, 2-entry in-order response buffer.
// Optional hardware pass/fail PC detection is enabled with the IMEM_PASSFAIL_EN macro.
module sodor_imem_port
   import sodor_imem_pkg::*;
#(
   parameter int          DEPTH     = 600,
   parameter logic [31:0] BASE_ADDR = 32'h80000000,
   parameter logic [31:0] PASS_ADDR = 32'h800004b0,
   parameter logic [31:0] FAIL_ADDR = 32'h80000494
) (
   input  logic            clock,
   input  logic            reset_n,
   input  logic            req_valid,
   output logic            req_ready,
   input  logic [31:0]     req_addr,
   output logic            resp_valid,
   input  logic            resp_ready,
   output logic [XLEN-1:0] resp_data,
   output logic            resp_err,
   output logic            test_pass,
   output logic            test_fail
);

   localparam int AW = $clog2(DEPTH);
   // Computed in 33 bits so a ROM ending at the top of the address space does not wrap.
   localparam logic [32:0] END_ADDR = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

   // Handshake: a transfer happens on a rising edge where valid && ready are both high;
   // req_ready depends only on registered occupancy, never on resp_ready.
   logic            req_fire, resp_fire, addr_err;
   logic [1:0]      occ_q, occ_next;
   logic [XLEN-1:0] offset, rom_dout;
   logic            s1_valid, s1_err;
   imem_resp_t      s1_resp, head;
   imem_resp_t      fifo [2];
   logic            wr_ptr, rd_ptr;
   logic [1:0]      fifo_cnt;
   logic            push, pop;

   assign req_ready = (occ_q < 2'd2);
   assign req_fire  = req_valid && req_ready;
   assign offset    = req_addr - BASE_ADDR;
   assign addr_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                      ({1'b0, req_addr} >= END_ADDR);

   sodor_imem_rom #(.DEPTH(DEPTH), .AW(AW)) mem_text (
      .clock (clock),
      .en    (req_fire && !addr_err),
      .addr  (AW'(offset >> 2)),
      .dout  (rom_dout)
   );

   // The word just read is presented directly when the buffer is empty, otherwise it queues.
   assign s1_resp    = '{data: (s1_err ? NOP_INSTR : rom_dout), err: s1_err};
   assign head       = (fifo_cnt != 2'd0) ? fifo[rd_ptr] : s1_resp;
   assign resp_valid = (fifo_cnt != 2'd0) || s1_valid;
   assign resp_data  = resp_valid ? head.data : '0;
   assign resp_err   = resp_valid && head.err;
   assign resp_fire  = resp_valid && resp_ready;
   assign push       = s1_valid && !((fifo_cnt == 2'd0) && resp_ready);
   assign pop        = resp_fire && (fifo_cnt != 2'd0);

   always_comb begin
      occ_next = occ_q;
      if (req_fire && !resp_fire)      occ_next = occ_q + 2'd1;
      else if (!req_fire && resp_fire) occ_next = occ_q - 2'd1;
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         occ_q    <= 2'd0;
         s1_valid <= 1'b0;
         s1_err   <= 1'b0;
         fifo_cnt <= 2'd0;
         wr_ptr   <= 1'b0;
         rd_ptr   <= 1'b0;
      end else begin
         occ_q    <= occ_next;
         s1_valid <= req_fire;
         if (req_fire) s1_err <= addr_err;
         if (push) wr_ptr <= ~wr_ptr;
         if (pop)  rd_ptr <= ~rd_ptr;
         fifo_cnt <= fifo_cnt + {1'b0, push} - {1'b0, pop};
      end
   end

   always_ff @(posedge clock) begin
      if (push) fifo[wr_ptr] <= s1_resp;
   end

`ifdef IMEM_PASSFAIL_EN
   logic pass_q, fail_q;

   // Whichever flag sets first locks out the other until reset.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         pass_q <= 1'b0;
         fail_q <= 1'b0;
      end else if (req_fire && !pass_q && !fail_q) begin
         if (req_addr == PASS_ADDR)      pass_q <= 1'b1;
         else if (req_addr == FAIL_ADDR) fail_q <= 1'b1;
      end
   end

   assign test_pass = pass_q;
   assign test_fail = fail_q;
`else
   assign test_pass = 1'b0;
   assign test_fail = 1'b0;
`endif

endmodule

// File: tb/tb_sodor_imem_port.sv
// Self-checking bench for sodor_imem_port: directed scenarios plus randomized traffic against a queue model.
module tb_sodor_imem_port;
   import sodor_imem_pkg::*;

   localparam int              DEPTH  = 600;
   localparam logic [31:0]     BASE32 = 32'h80000000;
   localparam longint unsigned BASE_L = 64'h80000000;
   localparam logic [31:0]     PASS32 = 32'h800004b0;
   localparam logic [31:0]     FAIL32 = 32'h80000494;
`ifdef IMEM_PASSFAIL_EN
   localparam logic PF_EN = 1'b1;
`else
   localparam logic PF_EN = 1'b0;
`endif

   logic        clock, reset_n;
   logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
   logic [31:0] req_addr, resp_data;
   logic        test_pass, test_fail;

   logic [31:0] rom_img [DEPTH];
   logic [32:0] exp_q [$];
   logic [32:0] held;
   logic        held_ok;
   int          n_cmp, n_fail;

   sodor_imem_port #(
      .DEPTH(DEPTH), .BASE_ADDR(BASE32), .PASS_ADDR(PASS32), .FAIL_ADDR(FAIL32)
   ) dut (
      .clock(clock), .reset_n(reset_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .resp_err(resp_err),
      .test_pass(test_pass), .test_fail(test_fail)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: what a fetch of byte address a must return, from the address rules and ROM image.
   function automatic logic [32:0] exp_of(input logic [31:0] a);
      longint unsigned la;
      int idx;
      la = 64'(a);
      if (a[1:0] != 2'b00 || la < BASE_L || la >= BASE_L + 4 * DEPTH) return {NOP_INSTR, 1'b1};
      idx = int'((la - BASE_L) / 4);
      return {rom_img[idx], 1'b0};
   endfunction

   function automatic logic [31:0] rand_addr();
      case ($urandom_range(0, 9))
         0:       return BASE32 + 32'($urandom_range(0, DEPTH - 1)) * 4 + 32'($urandom_range(1, 3));
         1:       return BASE32 + 32'(4 * DEPTH) + 32'($urandom_range(0, 15)) * 4;
         2:       return BASE32 - 32'($urandom_range(1, 16)) * 4;
         default: return BASE32 + 32'($urandom_range(0, DEPTH - 1)) * 4;
      endcase
   endfunction

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clock);
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_resp_valid: got %b expected 0", resp_valid); end
      n_cmp++; if (resp_data !== 32'h0) begin n_fail++; $display("FAIL reset_resp_data: got %h expected 0", resp_data); end
      n_cmp++; if (resp_err !== 1'b0) begin n_fail++; $display("FAIL reset_resp_err: got %b expected 0", resp_err); end
      n_cmp++; if (test_pass !== 1'b0 || test_fail !== 1'b0) begin
         n_fail++; $display("FAIL reset_flags: got pass=%b fail=%b expected 0 0", test_pass, test_fail);
      end
      reset_n = 1'b1;
      @(negedge clock);
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready: got %b expected 1", req_ready); end
   endtask

   task automatic test_single();
      @(negedge clock);
      resp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE32;
      n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL single_req_ready: got %b expected 1", req_ready); end
      @(negedge clock);
      req_valid = 1'b0;
      n_cmp++; if ({resp_valid, resp_data, resp_err} !== {1'b1, 32'h00000297, 1'b0}) begin
         n_fail++; $display("FAIL single_resp: got v=%b d=%h e=%b expected v=1 d=00000297 e=0", resp_valid, resp_data, resp_err);
      end
      resp_ready = 1'b1;
      @(negedge clock);
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL single_drain: got %b expected 0", resp_valid); end
   endtask

   task automatic test_back_to_back();
      logic [32:0] e;
      resp_ready = 1'b1;
      for (int i = 0; i <= 4; i++) begin
         @(negedge clock);
         if (i > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (resp_valid !== 1'b1 || {resp_data, resp_err} !== e) begin
               n_fail++; $display("FAIL b2b_resp%0d: got v=%b %h expected v=1 %h", i, resp_valid, {resp_data, resp_err}, e);
            end
         end
         if (i < 4) begin
            n_cmp++; if (req_ready !== 1'b1) begin n_fail++; $display("FAIL b2b_req_ready%0d: got %b expected 1", i, req_ready); end
            req_valid = 1'b1; req_addr = BASE32 + 32'(4 * i);
            exp_q.push_back(exp_of(req_addr));
         end else begin
            req_valid = 1'b0;
         end
      end
      @(negedge clock);
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %b expected 0", resp_valid); end
   endtask

   task automatic test_backpressure();
      logic [31:0] offers [$];
      logic [32:0] e;
      int accepted;
      accepted = 0;
      held_ok  = 1'b0;
      offers   = '{BASE32 + 32'h10, BASE32 + 32'h14, BASE32 + 32'h18};
      for (int c = 0; c < 30 && !(accepted == 3 && exp_q.size() == 0); c++) begin
         @(negedge clock);
         if (held_ok) begin
            n_cmp++; if (resp_valid !== 1'b1 || {resp_data, resp_err} !== held) begin
               n_fail++; $display("FAIL bp_hold: got v=%b %h expected v=1 %h", resp_valid, {resp_data, resp_err}, held);
            end
         end
         if (c == 4) begin
            n_cmp++; if (accepted != 2) begin n_fail++; $display("FAIL bp_accepted: got %0d expected 2", accepted); end
            n_cmp++; if (req_ready !== 1'b0) begin n_fail++; $display("FAIL bp_req_ready: got %b expected 0", req_ready); end
         end
         resp_ready = (c >= 4);
         req_valid  = (offers.size() != 0);
         req_addr   = (offers.size() != 0) ? offers[0] : 32'h0;
         if (resp_valid && resp_ready) begin
            e = exp_q.pop_front();
            n_cmp++; if ({resp_data, resp_err} !== e) begin
               n_fail++; $display("FAIL bp_order: got %h expected %h", {resp_data, resp_err}, e);
            end
         end
         if (req_valid && req_ready) begin
            exp_q.push_back(exp_of(req_addr));
            void'(offers.pop_front());
            accepted++;
         end
         held_ok = resp_valid && !resp_ready;
         held    = {resp_data, resp_err};
      end
      @(negedge clock);
      req_valid = 1'b0;
      n_cmp++; if (accepted != 3 || exp_q.size() != 0) begin
         n_fail++; $display("FAIL bp_timeout: got accepted=%0d pending=%0d expected 3 0", accepted, exp_q.size());
      end
   endtask

   task automatic test_errors();
      logic [31:0] bad [3];
      logic [32:0] e;
      bad = '{32'h80000002, 32'h80000960, 32'h7ffffffc};
      resp_ready = 1'b1;
      for (int i = 0; i <= 3; i++) begin
         @(negedge clock);
         if (i > 0) begin
            e = exp_q.pop_front();
            n_cmp++; if (resp_valid !== 1'b1 || resp_err !== 1'b1 || resp_data !== NOP_INSTR || {resp_data, resp_err} !== e) begin
               n_fail++; $display("FAIL err_resp%0d: got v=%b d=%h e=%b expected v=1 d=%h e=1", i, resp_valid, resp_data, resp_err, NOP_INSTR);
            end
         end
         if (i < 3) begin
            req_valid = 1'b1; req_addr = bad[i];
            exp_q.push_back(exp_of(req_addr));
         end else begin
            req_valid = 1'b0;
         end
      end
   endtask

   task automatic test_random();
      logic [32:0] e;
      held_ok = 1'b0;
      for (int c = 0; c < 340; c++) begin
         @(negedge clock);
         if (c > 300 && exp_q.size() == 0 && resp_valid === 1'b0) break;
         if (held_ok) begin
            n_cmp++; if (resp_valid !== 1'b1 || {resp_data, resp_err} !== held) begin
               n_fail++; $display("FAIL rand_hold: got v=%b %h expected v=1 %h", resp_valid, {resp_data, resp_err}, held);
            end
         end
         if (c < 300) begin
            resp_ready = ($urandom_range(0, 9) < 6);
            req_valid  = ($urandom_range(0, 9) < 7);
            req_addr   = rand_addr();
         end else begin
            resp_ready = 1'b1;
            req_valid  = 1'b0;
         end
         if (resp_valid && resp_ready) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_fail++; $display("FAIL rand_unexpected: got %h expected no response", {resp_data, resp_err});
            end else begin
               e = exp_q.pop_front();
               if ({resp_data, resp_err} !== e) begin
                  n_fail++; $display("FAIL rand_resp: got %h expected %h", {resp_data, resp_err}, e);
               end
            end
         end
         if (req_valid && req_ready) exp_q.push_back(exp_of(req_addr));
         held_ok = resp_valid && !resp_ready;
         held    = {resp_data, resp_err};
      end
      n_cmp++; if (exp_q.size() != 0 || resp_valid !== 1'b0) begin
         n_fail++; $display("FAIL rand_drain: got pending=%0d v=%b expected 0 0", exp_q.size(), resp_valid);
      end
   endtask

   task automatic test_passfail();
      @(negedge clock);
      reset_n = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      exp_q.delete();
      @(negedge clock);
      resp_ready = 1'b1; req_valid = 1'b1; req_addr = PASS32;
      @(negedge clock);
      req_valid = 1'b0;
      n_cmp++; if (test_pass !== PF_EN || test_fail !== 1'b0) begin
         n_fail++; $display("FAIL pf_pass_set: got pass=%b fail=%b expected %b 0", test_pass, test_fail, PF_EN);
      end
      repeat (3) @(negedge clock);
      req_valid = 1'b1; req_addr = FAIL32;
      @(negedge clock);
      req_valid = 1'b0;
      @(negedge clock);
      n_cmp++; if (test_pass !== PF_EN || test_fail !== 1'b0) begin
         n_fail++; $display("FAIL pf_sticky: got pass=%b fail=%b expected %b 0", test_pass, test_fail, PF_EN);
      end
      // Leave two responses buffered, then reset asynchronously mid-cycle.
      resp_ready = 1'b0; req_valid = 1'b1; req_addr = BASE32;
      @(negedge clock);
      req_addr = BASE32 + 32'h4;
      @(negedge clock);
      req_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      n_cmp++; if (resp_valid !== 1'b0 || test_pass !== 1'b0 || test_fail !== 1'b0 || req_ready !== 1'b1) begin
         n_fail++; $display("FAIL pf_reset: got v=%b pass=%b fail=%b rdy=%b expected 0 0 0 1", resp_valid, test_pass, test_fail, req_ready);
      end
      @(negedge clock);
      reset_n = 1'b1;
      resp_ready = 1'b1;
      @(negedge clock);
      n_cmp++; if (resp_valid !== 1'b0) begin n_fail++; $display("FAIL pf_discard: got %b expected 0", resp_valid); end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      req_valid = 1'b0; req_addr = 32'h0; resp_ready = 1'b0; reset_n = 1'b0;
      held = '0; held_ok = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         rom_img[i] = $urandom;
         if (i == 0) rom_img[i] = 32'h00000297;
         dut.mem_text.mem[i] = rom_img[i];
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_backpressure();
      test_errors();
      test_random();
      test_passfail();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
